// File: rtl/encoder.sv
// Streaming systematic Reed-Solomon encoder over GF(2^EGF_DIM).
// Each frame is MSG_CYC message words echoed with one cycle of latency, followed by
// PAR_CYC parity words. A free-running frame counter defines the framing; there is no handshake.
// Optional feature: define ENC_SOF_EN to add the registered enc_sof start-of-frame flag.
// rst_n is a synchronous reset that is ACTIVE-HIGH despite its name.

module encoder #(
  parameter int unsigned        EGF_DIM  = 8,
  parameter int unsigned        ENC_SYM  = 4,
  parameter int unsigned        MSG_CYC  = 12,
  parameter int unsigned        PAR_CYC  = 4,
  // Field polynomial without its implicit x^EGF_DIM term (0x11D -> 0x1D)
  parameter logic [EGF_DIM-1:0] GF_POLY  = 'h1D,
  parameter logic [EGF_DIM-1:0] GF_ALPHA = 'h02
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ENC_SYM*EGF_DIM-1:0] gen_data,
`ifdef ENC_SOF_EN
  output logic                       enc_sof,
`endif
  output logic [ENC_SYM*EGF_DIM-1:0] enc_data
);

  localparam int unsigned BusW     = ENC_SYM * EGF_DIM;
  localparam int unsigned NPar     = PAR_CYC * ENC_SYM;
  localparam int unsigned FrameCyc = MSG_CYC + PAR_CYC;
  localparam int unsigned CntW     = (FrameCyc > 1) ? $clog2(FrameCyc) : 1;

  typedef logic [EGF_DIM-1:0] sym_t;

  // GF(2^m) multiply; with one constant operand it reduces to a fixed XOR network.
  function automatic sym_t gf_mul(sym_t a, sym_t b);
    sym_t p;
    p = '0;
    for (int i = EGF_DIM - 1; i >= 0; i--) begin
      p = {p[EGF_DIM-2:0], 1'b0} ^ (p[EGF_DIM-1] ? GF_POLY : '0);
      if (b[i]) begin
        p = p ^ a;
      end
    end
    return p;
  endfunction

  // g(x) = prod (x - alpha^i), i = 0..NPar-1; returns g_0..g_{NPar-1} (monic term dropped).
  function automatic logic [NPar-1:0][EGF_DIM-1:0] gen_poly();
    logic [NPar:0][EGF_DIM-1:0] g;
    sym_t                       root;
    g    = '0;
    g[0] = sym_t'(1);
    root = sym_t'(1);
    for (int i = 0; i < int'(NPar); i++) begin
      for (int j = i + 1; j >= 1; j--) begin
        g[j] = g[j-1] ^ gf_mul(g[j], root);
      end
      g[0] = gf_mul(g[0], root);
      root = gf_mul(root, GF_ALPHA);
    end
    return g[NPar-1:0];
  endfunction

  localparam logic [NPar-1:0][EGF_DIM-1:0] GenCoef = gen_poly();

  logic [CntW-1:0]              cnt_q, cnt_d;
  logic [NPar-1:0][EGF_DIM-1:0] par_q, par_d, par_msg;
  logic [BusW-1:0]              enc_data_q, enc_data_d;
  logic                         msg_phase;
  logic                         last_cyc;
  sym_t                         fb;

  assign msg_phase = (cnt_q < CntW'(MSG_CYC));
  assign last_cyc  = (cnt_q == CntW'(FrameCyc - 1));

  // Absorb every symbol of the bus word into the parity LFSR, earliest symbol first.
  always_comb begin
    par_msg = par_q;
    fb      = '0;
    for (int s = 0; s < int'(ENC_SYM); s++) begin
      fb = gen_data[BusW-1-s*EGF_DIM -: EGF_DIM] ^ par_msg[NPar-1];
      for (int k = NPar - 1; k >= 1; k--) begin
        par_msg[k] = par_msg[k-1] ^ gf_mul(fb, GenCoef[k]);
      end
      par_msg[0] = gf_mul(fb, GenCoef[0]);
    end
  end

  // Next-state: echo message words, then shift parity out top-down; gen_data is not used
  // at all in parity slots so undefined input cannot reach the state.
  always_comb begin
    cnt_d = last_cyc ? '0 : cnt_q + CntW'(1);
    if (msg_phase) begin
      par_d      = par_msg;
      enc_data_d = gen_data;
    end else begin
      enc_data_d = par_q[NPar-1 -: ENC_SYM];
      par_d      = last_cyc ? '0 : (par_q << BusW);
    end
  end

  // State registers with synchronous, active-high reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt_q      <= '0;
      par_q      <= '0;
      enc_data_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      par_q      <= par_d;
      enc_data_q <= enc_data_d;
    end
  end

  assign enc_data = enc_data_q;

`ifdef ENC_SOF_EN
  logic enc_sof_q;

  // Flag the cycle whose output carries message word 0.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      enc_sof_q <= 1'b0;
    end else begin
      enc_sof_q <= (cnt_q == '0);
    end
  end

  assign enc_sof = enc_sof_q;
`endif

endmodule

// File: tb/tb_encoder.sv
// Self-checking bench for the RS(64,48) streaming encoder. Expected parity comes from
// textbook polynomial long division with log/antilog GF tables; every observed codeword is
// also checked for zero syndromes at alpha^0..alpha^15.

module tb_encoder;

  logic        clk;
  logic        rst_n;
  logic [31:0] gen_data;
  logic [31:0] enc_data;
`ifdef ENC_SOF_EN
  logic        enc_sof;
`endif

  encoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .gen_data (gen_data),
`ifdef ENC_SOF_EN
    .enc_sof  (enc_sof),
`endif
    .enc_data (enc_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  int exp_t [512];
  int log_t [256];
  int g_c   [17];

  logic [31:0] msg_w [12];
  logic [31:0] exp_w [16];
  logic [31:0] obs_w [16];

  function automatic int gmul(int a, int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[log_t[a] + log_t[b]];
  endfunction

  task automatic build_tables();
    int x;
    x = 1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = x;
      log_t[x] = i;
      x = x << 1;
      if ((x & 32'h100) != 0) x = x ^ 32'h11D;
    end
    for (int i = 255; i < 512; i++) exp_t[i] = exp_t[i-255];
    for (int i = 0; i < 17; i++) g_c[i] = 0;
    g_c[0] = 1;
    for (int i = 0; i < 16; i++) begin
      for (int j = i + 1; j >= 1; j--) g_c[j] = g_c[j-1] ^ gmul(g_c[j], exp_t[i]);
      g_c[0] = gmul(g_c[0], exp_t[i]);
    end
  endtask

  // Reference: remainder of m(x)*x^16 divided by g(x), by long division.
  task automatic model_frame();
    int c [64];
    int coef;
    for (int t = 0; t < 64; t++) c[t] = 0;
    for (int w = 0; w < 12; w++)
      for (int s = 0; s < 4; s++)
        c[63 - (w*4 + s)] = int'((msg_w[w] >> (8*(3-s))) & 32'hff);
    for (int deg = 63; deg >= 16; deg--) begin
      coef = c[deg];
      if (coef != 0)
        for (int k = 0; k <= 16; k++) c[deg-16+k] = c[deg-16+k] ^ gmul(coef, g_c[k]);
    end
    for (int w = 0; w < 12; w++) exp_w[w] = msg_w[w];
    for (int j = 0; j < 4; j++) begin
      exp_w[12+j] = '0;
      for (int s = 0; s < 4; s++) exp_w[12+j] = (exp_w[12+j] << 8) | 32'(c[15 - (j*4 + s)]);
    end
  endtask

  // Entry: just after a negedge, framing at cnt=0. xmode=1 drives X in parity slots.
  task automatic run_frame(input string tag, input int xmode);
    int          syn_or;
    int          acc;
    logic [31:0] sw;
    model_frame();
    for (int i = 0; i < 16; i++) begin
      if (i < 12) gen_data = msg_w[i];
      else if (xmode != 0) gen_data = 'x;
      else gen_data = $urandom;
      @(negedge clk);
      obs_w[i] = enc_data;
      n_cmp++;
      if (enc_data !== exp_w[i]) begin
        n_fail++;
        $display("FAIL %s word%0d: got %08h expected %08h", tag, i, enc_data, exp_w[i]);
      end
`ifdef ENC_SOF_EN
      n_cmp++;
      if (enc_sof !== (i == 0)) begin
        n_fail++;
        $display("FAIL %s sof%0d: got %b expected %b", tag, i, enc_sof, (i == 0));
      end
`endif
    end
    syn_or = 0;
    for (int r = 0; r < 16; r++) begin
      acc = 0;
      for (int t = 0; t < 64; t++) begin
        sw  = obs_w[t/4] >> (8*(3 - t%4));
        acc = gmul(acc, exp_t[r]) ^ int'(sw[7:0]);
      end
      syn_or = syn_or | acc;
    end
    n_cmp++;
    if (syn_or != 0) begin
      n_fail++;
      $display("FAIL %s syndrome: got or=%0h expected 0", tag, syn_or);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      gen_data = $urandom;
      @(negedge clk);
      n_cmp++;
      if (enc_data !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_hold%0d: got %08h expected 00000000", i, enc_data);
      end
`ifdef ENC_SOF_EN
      n_cmp++;
      if (enc_sof !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_sof%0d: got %b expected 0", i, enc_sof);
      end
`endif
    end
    rst_n = 1'b0;
    for (int w = 0; w < 12; w++) msg_w[w] = $urandom;
    run_frame("after_reset", 0);
  endtask

  task automatic test_zero();
    for (int w = 0; w < 12; w++) msg_w[w] = '0;
    run_frame("zero", 0);
  endtask

  task automatic test_impulse();
    logic [31:0] gw;
    for (int w = 0; w < 12; w++) msg_w[w] = '0;
    msg_w[11] = 32'h0000_0001;
    run_frame("impulse", 0);
    for (int j = 0; j < 4; j++) begin
      gw = '0;
      for (int s = 0; s < 4; s++) gw = (gw << 8) | 32'(g_c[15 - (j*4 + s)]);
      n_cmp++;
      if (obs_w[12+j] !== gw) begin
        n_fail++;
        $display("FAIL impulse_gen%0d: got %08h expected %08h", j, obs_w[12+j], gw);
      end
    end
  endtask

  task automatic test_alternating();
    for (int f = 0; f < 4; f++) begin
      for (int w = 0; w < 12; w++) msg_w[w] = (w % 2 == 0) ? 32'h0123_4567 : 32'h89ab_cdef;
      run_frame("alternating", 1);
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      for (int w = 0; w < 12; w++) msg_w[w] = $urandom;
      if (f == 1) msg_w[0] = 32'hffff_ffff;
      run_frame("random", 0);
    end
  endtask

  task automatic test_reset_mid();
    for (int w = 0; w < 12; w++) msg_w[w] = $urandom;
    for (int i = 0; i < 7; i++) begin
      gen_data = msg_w[i];
      @(negedge clk);
      n_cmp++;
      if (enc_data !== msg_w[i]) begin
        n_fail++;
        $display("FAIL midreset_echo%0d: got %08h expected %08h", i, enc_data, msg_w[i]);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      gen_data = $urandom;
      @(negedge clk);
      n_cmp++;
      if (enc_data !== 32'h0) begin
        n_fail++;
        $display("FAIL midreset_hold%0d: got %08h expected 00000000", i, enc_data);
      end
`ifdef ENC_SOF_EN
      n_cmp++;
      if (enc_sof !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_sof%0d: got %b expected 0", i, enc_sof);
      end
`endif
    end
    rst_n = 1'b0;
    for (int w = 0; w < 12; w++) msg_w[w] = $urandom;
    run_frame("fresh_frame", 0);
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    gen_data = '0;
    build_tables();
    test_reset();
    test_zero();
    test_impulse();
    test_alternating();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
